// File: rtl/hazard5_bus_arbiter_if.sv
// AHB-Lite master-port signal bundle shared between the Hazard5 bus arbiter
// (master side) and the system bus / slave model (slave side).
interface hazard5_bus_arbiter_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) ();

  logic [W_ADDR-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output haddr,
    output htrans,
    output hwrite,
    output hsize,
    output hwdata,
    input  hrdata,
    input  hready,
    input  hresp
  );

  modport slave (
    input  haddr,
    input  htrans,
    input  hwrite,
    input  hsize,
    input  hwdata,
    output hrdata,
    output hready,
    output hresp
  );

endinterface

// File: rtl/hazard5_bus_arbiter.sv
// Arbitrates instruction fetch and load/store onto one AHB-Lite master port,
// tracking the data-phase owner and routing responses back to it.
module hazard5_bus_arbiter #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              f_req,
  input  logic [W_ADDR-1:0] f_addr,
  output logic              f_aph_ready,
  output logic              f_dph_ready,
  output logic              f_dph_err,
  output logic [W_DATA-1:0] f_rdata,

  input  logic              x_req,
  input  logic [W_ADDR-1:0] x_addr,
  input  logic              x_write,
  input  logic [1:0]        x_size,
  input  logic [W_DATA-1:0] x_wdata,
  output logic              x_aph_ready,
  output logic              x_dph_ready,
  output logic              x_dph_err,
  output logic [W_DATA-1:0] x_rdata,

  hazard5_bus_arbiter_if.master ahb
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LS    = 2'd2
  } owner_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Fetches are always word-aligned; clear the low two address bits.
  localparam logic [W_ADDR-1:0] WORD_MASK = ~W_ADDR'(3);

  owner_t aph_lock_reg, aph_lock_next;
  owner_t dph_owner_reg, dph_owner_next;
  owner_t grant;
  logic   err_cancel;
  logic   issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph_lock_reg  <= OWN_NONE;
      dph_owner_reg <= OWN_NONE;
    end else begin
      aph_lock_reg  <= aph_lock_next;
      dph_owner_reg <= dph_owner_next;
    end
  end

  // First cycle of a two-cycle ERROR response: the pending address phase is dropped.
  always_comb begin
    err_cancel = ahb.hresp && !ahb.hready;

    grant = OWN_NONE;
    if (aph_lock_reg != OWN_NONE) begin
      grant = aph_lock_reg;
    end else if (x_req) begin
      grant = OWN_LS;
    end else if (f_req) begin
      grant = OWN_FETCH;
    end

    issue = (grant != OWN_NONE) && !err_cancel;
  end

  always_comb begin
    ahb.htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    ahb.haddr  = f_addr & WORD_MASK;
    ahb.hsize  = 3'b010;
    ahb.hwrite = 1'b0;
    if (grant == OWN_LS) begin
      ahb.haddr  = x_addr;
      ahb.hsize  = {1'b0, x_size};
      ahb.hwrite = x_write;
    end
    ahb.hwdata = x_wdata;

    f_aph_ready = (grant == OWN_FETCH) && ahb.hready && !err_cancel;
    x_aph_ready = (grant == OWN_LS)    && ahb.hready && !err_cancel;
  end

  // Lock holds an issued-but-stalled address phase so it stays stable.
  always_comb begin
    aph_lock_next = aph_lock_reg;
    if (err_cancel || ahb.hready) begin
      aph_lock_next = OWN_NONE;
    end else if (issue) begin
      aph_lock_next = grant;
    end

    dph_owner_next = dph_owner_reg;
    if (ahb.hready) begin
      dph_owner_next = issue ? grant : OWN_NONE;
    end
  end

  always_comb begin
    f_dph_ready = (dph_owner_reg == OWN_FETCH) && ahb.hready;
    x_dph_ready = (dph_owner_reg == OWN_LS)    && ahb.hready;
    f_dph_err   = f_dph_ready && ahb.hresp;
    x_dph_err   = x_dph_ready && ahb.hresp;
    f_rdata     = ahb.hrdata;
    x_rdata     = ahb.hrdata;
  end

endmodule

// File: tb/tb_hazard5_bus_arbiter.sv
// Directed bench for hazard5_bus_arbiter: inputs change on the falling edge,
// combinational outputs are checked 1 ns later, state advances on the rising edge.
module tb_hazard5_bus_arbiter;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  logic              clk;
  logic              rst_n;
  logic              f_req;
  logic [W_ADDR-1:0] f_addr;
  logic              f_aph_ready, f_dph_ready, f_dph_err;
  logic [W_DATA-1:0] f_rdata;
  logic              x_req;
  logic [W_ADDR-1:0] x_addr;
  logic              x_write;
  logic [1:0]        x_size;
  logic [W_DATA-1:0] x_wdata;
  logic              x_aph_ready, x_dph_ready, x_dph_err;
  logic [W_DATA-1:0] x_rdata;

  int n_checks = 0;
  int n_errors = 0;

  hazard5_bus_arbiter_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) ahb ();

  hazard5_bus_arbiter #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_aph_ready (f_aph_ready),
    .f_dph_ready (f_dph_ready),
    .f_dph_err   (f_dph_err),
    .f_rdata     (f_rdata),
    .x_req       (x_req),
    .x_addr      (x_addr),
    .x_write     (x_write),
    .x_size      (x_size),
    .x_wdata     (x_wdata),
    .x_aph_ready (x_aph_ready),
    .x_dph_ready (x_dph_ready),
    .x_dph_err   (x_dph_err),
    .x_rdata     (x_rdata),
    .ahb         (ahb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Address/control must not move while a stalled, non-error address phase is pending.
  logic              prev_stall;
  logic [W_ADDR-1:0] prev_haddr;
  logic [2:0]        prev_hsize;
  logic              prev_hwrite;
  always @(posedge clk) begin
    if (rst_n && prev_stall) begin
      assert (ahb.haddr == prev_haddr && ahb.hsize == prev_hsize &&
              ahb.hwrite == prev_hwrite && ahb.htrans == 2'b10)
        else $error("FAIL lock_stable: haddr 0x%0h was 0x%0h", ahb.haddr, prev_haddr);
    end
    prev_stall  = rst_n && (ahb.htrans == 2'b10) && !ahb.hready && !ahb.hresp;
    prev_haddr  = ahb.haddr;
    prev_hsize  = ahb.hsize;
    prev_hwrite = ahb.hwrite;
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [5:0] all_flags();
    return {f_aph_ready, f_dph_ready, f_dph_err, x_aph_ready, x_dph_ready, x_dph_err};
  endfunction

  initial begin
    rst_n      = 1'b0;
    f_req      = 1'b0;
    f_addr     = '0;
    x_req      = 1'b0;
    x_addr     = '0;
    x_write    = 1'b0;
    x_size     = 2'd0;
    x_wdata    = 32'hA5A5_0000;
    ahb.hrdata = 32'h0;
    ahb.hready = 1'b1;
    ahb.hresp  = 1'b0;
    prev_stall = 1'b0;

    // Reset state
    repeat (2) next_cycle();
    settle();
    check("reset_htrans", ahb.htrans, 2'b00);
    check("reset_flags", all_flags(), 6'b0);
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("post_reset_htrans", ahb.htrans, 2'b00);
    check("hwdata_pass", ahb.hwdata, 32'hA5A5_0000);

    // Single fetch
    next_cycle();
    f_req = 1'b1; f_addr = 32'h103;
    settle();
    check("sf_haddr", ahb.haddr, 32'h100);
    check("sf_htrans", ahb.htrans, 2'b10);
    check("sf_hsize", ahb.hsize, 3'd2);
    check("sf_hwrite", ahb.hwrite, 1'b0);
    check("sf_f_aph", f_aph_ready, 1'b1);
    check("sf_x_aph", x_aph_ready, 1'b0);
    check("sf_f_dph_early", f_dph_ready, 1'b0);
    next_cycle();
    f_req = 1'b0; ahb.hrdata = 32'hDEAD_BEEF;
    settle();
    check("sf_f_dph", f_dph_ready, 1'b1);
    check("sf_f_rdata", f_rdata, 32'hDEAD_BEEF);
    check("sf_x_dph", x_dph_ready, 1'b0);
    check("sf_htrans_idle", ahb.htrans, 2'b00);
    next_cycle();
    settle();
    check("sf_f_dph_done", f_dph_ready, 1'b0);

    // Simultaneous requests: LS first, then fetch
    next_cycle();
    f_req = 1'b1; f_addr = 32'h400;
    x_req = 1'b1; x_addr = 32'h2002; x_size = 2'd1; x_write = 1'b1;
    settle();
    check("sim_haddr_ls", ahb.haddr, 32'h2002);
    check("sim_hsize_ls", ahb.hsize, 3'd1);
    check("sim_hwrite_ls", ahb.hwrite, 1'b1);
    check("sim_x_aph", x_aph_ready, 1'b1);
    check("sim_f_aph_blocked", f_aph_ready, 1'b0);
    next_cycle();
    x_req = 1'b0; x_write = 1'b0;
    settle();
    check("sim_haddr_f", ahb.haddr, 32'h400);
    check("sim_hsize_f", ahb.hsize, 3'd2);
    check("sim_f_aph", f_aph_ready, 1'b1);
    check("sim_x_dph", x_dph_ready, 1'b1);
    check("sim_f_dph_early", f_dph_ready, 1'b0);
    next_cycle();
    f_req = 1'b0;
    settle();
    check("sim_f_dph", f_dph_ready, 1'b1);
    check("sim_x_dph_done", x_dph_ready, 1'b0);

    // Wait-state lock: fetch stalled three cycles while x_req rises
    next_cycle();
    f_req = 1'b1; f_addr = 32'h802; ahb.hready = 1'b0;
    settle();
    check("ws_haddr_0", ahb.haddr, 32'h800);
    check("ws_htrans_0", ahb.htrans, 2'b10);
    check("ws_f_aph_0", f_aph_ready, 1'b0);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      x_req = 1'b1; x_addr = 32'h3000; x_size = 2'd2; x_write = 1'b0;
      settle();
      check($sformatf("ws_haddr_%0d", i), ahb.haddr, 32'h800);
      check($sformatf("ws_hsize_%0d", i), ahb.hsize, 3'd2);
      check($sformatf("ws_x_aph_%0d", i), x_aph_ready, 1'b0);
    end
    next_cycle();
    ahb.hready = 1'b1;
    settle();
    check("ws_f_aph_accept", f_aph_ready, 1'b1);
    check("ws_x_aph_still0", x_aph_ready, 1'b0);
    check("ws_haddr_accept", ahb.haddr, 32'h800);
    next_cycle();
    f_req = 1'b0;
    settle();
    check("ws_x_haddr", ahb.haddr, 32'h3000);
    check("ws_x_aph", x_aph_ready, 1'b1);
    check("ws_f_dph", f_dph_ready, 1'b1);
    next_cycle();
    x_req = 1'b0;
    settle();
    check("ws_x_dph", x_dph_ready, 1'b1);
    check("ws_f_dph_done", f_dph_ready, 1'b0);

    // Error response on an LS data phase with fetch pending
    next_cycle();
    x_req = 1'b1; x_addr = 32'h5000; x_size = 2'd2;
    settle();
    check("err_x_aph", x_aph_ready, 1'b1);
    next_cycle();
    x_req = 1'b0; f_req = 1'b1; f_addr = 32'h600;
    ahb.hresp = 1'b1; ahb.hready = 1'b0;
    settle();
    check("err_c1_htrans", ahb.htrans, 2'b00);
    check("err_c1_f_aph", f_aph_ready, 1'b0);
    check("err_c1_x_dph", x_dph_ready, 1'b0);
    check("err_c1_x_err", x_dph_err, 1'b0);
    next_cycle();
    ahb.hready = 1'b1;
    settle();
    check("err_c2_x_dph", x_dph_ready, 1'b1);
    check("err_c2_x_err", x_dph_err, 1'b1);
    check("err_c2_f_err", f_dph_err, 1'b0);
    check("err_c2_htrans", ahb.htrans, 2'b10);
    check("err_c2_haddr", ahb.haddr, 32'h600);
    check("err_c2_f_aph", f_aph_ready, 1'b1);
    next_cycle();
    f_req = 1'b0; ahb.hresp = 1'b0;
    settle();
    check("err_c3_f_dph", f_dph_ready, 1'b1);
    check("err_c3_f_err", f_dph_err, 1'b0);
    check("err_c3_x_err", x_dph_err, 1'b0);

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      settle();
      check($sformatf("idle_htrans_%0d", i), ahb.htrans, 2'b00);
      check($sformatf("idle_flags_%0d", i), all_flags(), 6'b0);
    end

    // Reset during a wait-stated load
    next_cycle();
    x_req = 1'b1; x_addr = 32'h7000; x_write = 1'b0;
    settle();
    check("rst_x_aph", x_aph_ready, 1'b1);
    next_cycle();
    x_req = 1'b0; ahb.hready = 1'b0;
    settle();
    check("rst_x_dph_wait", x_dph_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_htrans", ahb.htrans, 2'b00);
    next_cycle();
    ahb.hready = 1'b1;
    settle();
    check("rst_hold_x_dph", x_dph_ready, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("rst_rel_x_dph", x_dph_ready, 1'b0);
    check("rst_rel_htrans", ahb.htrans, 2'b00);
    next_cycle();
    settle();
    check("rst_after_flags", all_flags(), 6'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard5_bus_arbiter.md
# hazard5_bus_arbiter

Arbiter between the Hazard5 instruction fetch unit and the load/store unit. Both share one AHB-Lite master port, and this block sits between the core's fetch/X stages and the system bus. It grants each address phase, tracks which requester owns the data phase in flight, holds grants stable across wait states, and routes ready, data and error responses back to the requester that owns them.

## Interface
Parameters:
- W_ADDR, 32, address width
- W_DATA, 32, bus data width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch address-phase request
- f_addr  in  W_ADDR  fetch address; bits [1:0] ignored
- f_aph_ready  out  1  fetch address phase accepted this cycle
- f_dph_ready  out  1  fetch data phase completes this cycle
- f_dph_err  out  1  fetch data phase ended with ERROR
- f_rdata  out  W_DATA  fetch read data (hrdata passthrough)
- x_req  in  1  load/store address-phase request
- x_addr  in  W_ADDR  load/store address
- x_write  in  1  1 = store
- x_size  in  2  0 = byte, 1 = half, 2 = word
- x_wdata  in  W_DATA  store data, presented during the data phase
- x_aph_ready  out  1  load/store address phase accepted
- x_dph_ready  out  1  load/store data phase completes
- x_dph_err  out  1  load/store data phase ended with ERROR
- x_rdata  out  W_DATA  load data (hrdata passthrough)
- haddr  out  W_ADDR  AHB address
- htrans  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are used
- hwrite  out  1  AHB write
- hsize  out  3  AHB size
- hwdata  out  W_DATA  AHB write data; equal to x_wdata
- hrdata  in  W_DATA  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB response; 1 = ERROR

## Operation
- Grant selection, combinational, each cycle:
  - If aph_lock is set, the grant is the locked requester.
  - Otherwise x_req wins over f_req.
  - Otherwise no grant.
- Address-phase outputs with a grant:
  - htrans = NONSEQ.
  - Fetch grant: haddr = {f_addr[W_ADDR-1:2], 2'b00}, hsize = 3'b010, hwrite = 0.
  - Load/store grant: haddr = x_addr, hsize = {1'b0, x_size}, hwrite = x_write.
- Address-phase outputs with no grant: htrans = IDLE, and haddr/hsize/hwrite take the fetch values.
- Acceptance: the granted requester's *_aph_ready = grant && hready && !err_cancel.
- aph_lock register, with states NONE / FETCH / LS:
  - Set to the granted requester when htrans = NONSEQ and hready = 0, so the address stays stable per AHB-Lite.
  - Cleared on the cycle hready = 1, and also on err_cancel.
  - While a lock is held, the requester must keep its req and address/control stable. This is a requester obligation; the bench checks it with an assertion.
- dph_owner register, with states NONE / FETCH / LS:
  - When hready = 1, it loads the accepted requester, or NONE if nothing was accepted.
  - When hready = 0, it holds.
- Data-phase completion:
  - f_dph_ready = (dph_owner == FETCH) && hready.
  - x_dph_ready = (dph_owner == LS) && hready.
  - *_dph_err = the owner's *_dph_ready && hresp.
  - f_rdata = x_rdata = hrdata.
- Error handling:
  - err_cancel = hresp && !hready, i.e. the first cycle of a two-cycle ERROR response.
  - During err_cancel, htrans is forced to IDLE and no aph_ready is given, so the pending address phase is cancelled.
  - The cancelled requester re-requests in the next cycle if it still wants the transfer.
  - dph_owner is kept through both error cycles.
- Reset: aph_lock = NONE and dph_owner = NONE.
  - All *_dph_ready and *_dph_err outputs are 0.
  - All *_aph_ready outputs are 0 whenever the requests are low.
  - htrans = IDLE whenever f_req = x_req = 0.

## Timing
- Address issue has zero cycles of latency: req to htrans is a combinational path.
- The data phase completes at the earliest one cycle after address acceptance. Wait states extend it for as long as hready = 0.
- Back-to-back transfers are supported: a new address phase can be accepted on the same edge that a data phase completes.
- If both requests rise in the same cycle with no lock, LS is granted. Fetch is granted on the next free cycle.
- The lock takes precedence over priority: if x_req rises while a fetch address phase is locked, fetch keeps the grant until hready = 1.
- Reset asserted mid-transfer clears all state immediately. After reset the bus is left IDLE, and the slave's outstanding response is ignored.

## Test plan
- Single fetch: f_req = 1, f_addr = 0x103, hready = 1 → haddr = 0x100, htrans = NONSEQ, hsize = 2, f_aph_ready = 1; on the next cycle f_dph_ready = 1 and f_rdata = hrdata.
- Simultaneous requests: f_req = x_req = 1, x_addr = 0x2002, x_size = 1, x_write = 1 → LS is granted first (hsize = 1, hwrite = 1), fetch is granted on the following cycle, and dph_owner sequences LS then FETCH.
- Wait-state lock: fetch address issued with hready = 0 for 3 cycles, and x_req asserted during the stall → haddr, htrans and hsize are stable all 3 cycles, and x_aph_ready stays 0 until the fetch is accepted.
- Error response: LS data phase returns hresp = 1/hready = 0, then hresp = 1/hready = 1, with f_req pending → htrans = IDLE during the first cycle, x_dph_err = 1 in the second cycle, fetch is reissued, and f_dph_err is never 1.
- Idle bus: no requests for 10 cycles → htrans = IDLE, and every *_ready and *_err output is 0.
- Reset during a wait-stated load → after release, dph_owner = NONE, x_dph_ready is never pulsed for the killed transfer, and htrans = IDLE.
